// File: rtl/fetch_unit_if.sv
// Byte-wide memory read port and decode-side valid/ready handshake of the fetch stage.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 8
);
    logic                 mem_rd_en;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_ack;
    logic [DATA_BITS-1:0] mem_rd_data;

    logic [15:0]          instr;
    logic [ADDR_BITS-1:0] instr_addr;
    logic                 instr_valid;
    logic                 instr_ready;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_ack,
        input  mem_rd_data,
        output instr,
        output instr_addr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_ack,
        output mem_rd_data,
        input  instr,
        input  instr_addr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads 16-bit big-endian instructions as two bytes and hands them
// to decode; handles relative jumps, interrupt entry and interrupt return.
module fetch_unit #(
    parameter int                   ADDR_BITS        = 16,
    parameter int                   DATA_BITS        = 8,
    parameter int                   JUMP_OFFSET_BITS = 8,
    parameter logic [ADDR_BITS-1:0] RESET_ADDRESS    = 16'h0000,
    parameter logic [ADDR_BITS-1:0] ISR_ADDRESS      = 16'hff00
) (
    input  logic                        clk,
    input  logic                        reset_n,
    fetch_unit_if.master                bus,
    input  logic                        jump_valid,
    input  logic [JUMP_OFFSET_BITS-1:0] jump_offset,
    input  logic                        irq_req,
    output logic                        irq_ack,
    input  logic                        iret,
    output logic                        in_isr,
    output logic [ADDR_BITS-1:0]        saved_ip
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_HI,
        FETCH_LO,
        DELIVER
    } state_t;

    state_t               state, state_next;
    logic [ADDR_BITS-1:0] ip, ip_next;
    logic [ADDR_BITS-1:0] last_addr, last_addr_next;
    logic [15:0]          instr_q, instr_next;
    logic [ADDR_BITS-1:0] instr_addr_q, instr_addr_next;
    logic                 in_isr_q, in_isr_next;
    logic [ADDR_BITS-1:0] saved_ip_q, saved_ip_next;
    logic                 irq_take;
    logic                 iret_take;
    logic [DATA_BITS-1:0] rd_byte;
    logic [ADDR_BITS-1:0] jump_target;

    assign rd_byte     = bus.mem_rd_data;
    // Jumps are relative to the instruction after the last one decode actually accepted.
    assign jump_target = last_addr + ADDR_BITS'(2) + ADDR_BITS'($signed(jump_offset));
    assign iret_take   = iret && in_isr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ip           <= RESET_ADDRESS;
            last_addr    <= RESET_ADDRESS - ADDR_BITS'(2);
            instr_q      <= '0;
            instr_addr_q <= '0;
            in_isr_q     <= 1'b0;
            saved_ip_q   <= '0;
        end else begin
            state        <= state_next;
            ip           <= ip_next;
            last_addr    <= last_addr_next;
            instr_q      <= instr_next;
            instr_addr_q <= instr_addr_next;
            in_isr_q     <= in_isr_next;
            saved_ip_q   <= saved_ip_next;
        end
    end

    // A jump or iret wins over everything in flight: pending reads and a same-cycle
    // handshake are both abandoned, so last_addr only moves on an undisturbed accept.
    always_comb begin
        state_next      = state;
        ip_next         = ip;
        last_addr_next  = last_addr;
        instr_next      = instr_q;
        instr_addr_next = instr_addr_q;
        in_isr_next     = in_isr_q;
        saved_ip_next   = saved_ip_q;
        irq_take        = 1'b0;

        if (jump_valid) begin
            ip_next    = jump_target;
            state_next = IDLE;
        end else if (iret_take) begin
            ip_next     = saved_ip_q;
            in_isr_next = 1'b0;
            state_next  = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = FETCH_HI;
                    if (irq_req && !in_isr_q) begin
                        irq_take      = 1'b1;
                        saved_ip_next = ip;
                        ip_next       = ISR_ADDRESS;
                        in_isr_next   = 1'b1;
                    end
                end
                FETCH_HI: begin
                    if (bus.mem_ack) begin
                        instr_next[15:8] = rd_byte;
                        state_next       = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (bus.mem_ack) begin
                        instr_next[7:0] = rd_byte;
                        instr_addr_next = ip;
                        state_next      = DELIVER;
                    end
                end
                DELIVER: begin
                    if (bus.instr_ready) begin
                        last_addr_next = instr_addr_q;
                        ip_next        = ip + ADDR_BITS'(2);
                        state_next     = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_en   = (state == FETCH_HI) || (state == FETCH_LO);
    assign bus.mem_addr    = (state == FETCH_LO) ? ip + ADDR_BITS'(1) : ip;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = instr_addr_q;
    assign bus.instr_valid = (state == DELIVER);
    assign irq_ack         = irq_take;
    assign in_isr          = in_isr_q;
    assign saved_ip        = saved_ip_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_fetch_unit;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    int compared   = 0;
    int mismatched = 0;

    fetch_unit_if #(.ADDR_BITS(16), .DATA_BITS(8)) bus ();
    logic        jump_valid, iret, irq_req, irq_ack, in_isr;
    logic [7:0]  jump_offset;
    logic [15:0] saved_ip;

    fetch_unit #(
        .ADDR_BITS(16), .DATA_BITS(8), .JUMP_OFFSET_BITS(8),
        .RESET_ADDRESS(16'h0000), .ISR_ADDRESS(16'hff00)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .jump_valid(jump_valid), .jump_offset(jump_offset),
        .irq_req(irq_req), .irq_ack(irq_ack), .iret(iret),
        .in_isr(in_isr), .saved_ip(saved_ip)
    );

    // Second instance starting at the top of memory, zero-wait memory, always-ready decode.
    fetch_unit_if #(.ADDR_BITS(16), .DATA_BITS(8)) wbus ();
    logic        w_jump;
    logic [7:0]  w_off;
    logic        w_irq_ack, w_in_isr;
    logic [15:0] w_saved_ip;

    fetch_unit #(
        .ADDR_BITS(16), .DATA_BITS(8), .JUMP_OFFSET_BITS(8),
        .RESET_ADDRESS(16'hffff), .ISR_ADDRESS(16'hff00)
    ) wdut (
        .clk(clk), .reset_n(reset_n), .bus(wbus),
        .jump_valid(w_jump), .jump_offset(w_off),
        .irq_req(1'b0), .irq_ack(w_irq_ack), .iret(1'b0),
        .in_isr(w_in_isr), .saved_ip(w_saved_ip)
    );

    assign wbus.mem_ack     = wbus.mem_rd_en;
    assign wbus.mem_rd_data = mem[wbus.mem_addr];
    assign wbus.instr_ready = 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic jv, input logic [7:0] off, input logic irt,
                                 input logic irq, input logic rdy);
        jump_valid      = jv;
        jump_offset     = off;
        iret            = irt;
        irq_req         = irq;
        bus.instr_ready = rdy;
    endtask

    // Memory responder: acknowledges each request after a configurable number of wait cycles.
    int ack_cnt    = 0;
    int ack_delay  = 0;
    int cur_delay  = 0;
    bit rand_delay = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!bus.mem_rd_en) begin
            bus.mem_ack = 1'b0;
            ack_cnt     = 0;
        end else begin
            if (bus.mem_ack) ack_cnt = 0;
            if (ack_cnt == 0) cur_delay = rand_delay ? int'($urandom_range(0, 2)) : ack_delay;
            if (ack_cnt >= cur_delay) begin
                bus.mem_ack     = 1'b1;
                bus.mem_rd_data = mem[bus.mem_addr];
            end else begin
                bus.mem_ack     = 1'b0;
                bus.mem_rd_data = 8'($urandom);
                ack_cnt++;
            end
        end
    end

    // Reference model: pointer, bytes collected so far, and whether we sit at a boundary.
    logic [15:0] m_ip, m_last, m_saved, m_iaddr, m_instr;
    logic        m_in_isr, m_boundary;
    int          m_bytes;

    task automatic modelReset();
        m_ip       = 16'h0000;
        m_last     = 16'hfffe;
        m_saved    = 16'h0000;
        m_iaddr    = 16'h0000;
        m_instr    = 16'h0000;
        m_in_isr   = 1'b0;
        m_boundary = 1'b1;
        m_bytes    = 0;
    endtask

    task automatic modelStep();
        logic [15:0] sext;
        sext = {{8{jump_offset[7]}}, jump_offset};
        if (jump_valid) begin
            m_ip       = m_last + 16'd2 + sext;
            m_boundary = 1'b1;
            m_bytes    = 0;
        end else if (iret && m_in_isr) begin
            m_ip       = m_saved;
            m_in_isr   = 1'b0;
            m_boundary = 1'b1;
            m_bytes    = 0;
        end else if (m_boundary) begin
            if (irq_req && !m_in_isr) begin
                m_saved  = m_ip;
                m_ip     = 16'hff00;
                m_in_isr = 1'b1;
            end
            m_boundary = 1'b0;
            m_bytes    = 0;
        end else if (m_bytes == 0) begin
            if (bus.mem_ack) begin
                m_instr[15:8] = bus.mem_rd_data;
                m_bytes       = 1;
            end
        end else if (m_bytes == 1) begin
            if (bus.mem_ack) begin
                m_instr[7:0] = bus.mem_rd_data;
                m_iaddr      = m_ip;
                m_bytes      = 2;
            end
        end else if (bus.instr_ready) begin
            m_last     = m_iaddr;
            m_ip       = m_ip + 16'd2;
            m_boundary = 1'b1;
            m_bytes    = 0;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) modelReset();
        else          modelStep();
    end

    always @(negedge clk) begin : cmp
        logic        e_rd_en, e_valid, e_irq_ack;
        logic [15:0] e_addr, nxt;
        if (reset_n) begin
            e_rd_en   = !m_boundary && (m_bytes < 2);
            e_valid   = !m_boundary && (m_bytes == 2);
            e_addr    = m_ip + ((!m_boundary && m_bytes == 1) ? 16'd1 : 16'd0);
            e_irq_ack = m_boundary && irq_req && !m_in_isr && !jump_valid && !(iret && m_in_isr);
            checkOutput("mem_rd_en", 32'(bus.mem_rd_en), 32'(e_rd_en));
            checkOutput("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            checkOutput("instr_valid", 32'(bus.instr_valid), 32'(e_valid));
            checkOutput("irq_ack", 32'(irq_ack), 32'(e_irq_ack));
            checkOutput("in_isr", 32'(in_isr), 32'(m_in_isr));
            checkOutput("saved_ip", 32'(saved_ip), 32'(m_saved));
            checkOutput("instr", 32'(bus.instr), 32'(m_instr));
            checkOutput("instr_addr", 32'(bus.instr_addr), 32'(m_iaddr));
            if (e_valid) begin
                nxt = m_iaddr + 16'd1;
                checkOutput("instr_vs_mem", 32'(bus.instr), 32'({mem[m_iaddr], mem[nxt]}));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Wrap-around scenario on the second instance.
    initial begin : wrap_seq
        logic found;
        w_jump = 1'b0;
        w_off  = 8'h00;
        @(posedge reset_n);
        @(negedge clk);
        checkOutput("wrap_addr_hi", 32'(wbus.mem_addr), 32'h0000ffff);
        @(negedge clk);
        checkOutput("wrap_addr_lo", 32'(wbus.mem_addr), 32'h00000000);
        @(negedge clk);
        checkOutput("wrap_valid", 32'(wbus.instr_valid), 32'd1);
        checkOutput("wrap_instr_addr", 32'(wbus.instr_addr), 32'h0000ffff);
        checkOutput("wrap_instr", 32'(wbus.instr), 32'h0000ab12);
        checkOutput("wrap_in_isr", 32'(w_in_isr), 32'd0);
        @(posedge clk); #1;
        w_jump = 1'b1;
        w_off  = 8'hfd;
        @(posedge clk); #1;
        w_jump = 1'b0;
        @(negedge clk);
        checkOutput("wrap_jump_fffe", 32'(wbus.mem_addr), 32'h0000fffe);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (wbus.instr_valid) found = 1'b1;
        end
        checkOutput("wrap_reach_fffe", 32'(found), 32'd1);
        checkOutput("wrap_fffe_addr", 32'(wbus.instr_addr), 32'h0000fffe);
        @(posedge clk); #1;
        w_jump = 1'b1;
        w_off  = 8'h04;
        @(posedge clk); #1;
        w_jump = 1'b0;
        @(negedge clk);
        checkOutput("wrap_jump_0004", 32'(wbus.mem_addr), 32'h00000004);
        checkOutput("wrap_irq_ack", 32'(w_irq_ack), 32'd0);
        checkOutput("wrap_saved_ip", 32'(w_saved_ip), 32'd0);
    end

    initial begin : main_seq
        logic found;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[16'hffff] = 8'hab;
        bus.mem_ack     = 1'b0;
        bus.mem_rd_data = 8'h00;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        #1 reset_n = 1'b0;
        #2;
        checkOutput("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        checkOutput("rst_instr", 32'(bus.instr), 32'h0);
        checkOutput("rst_instr_addr", 32'(bus.instr_addr), 32'h0);
        checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("rst_irq_ack", 32'(irq_ack), 32'd0);
        checkOutput("rst_in_isr", 32'(in_isr), 32'd0);
        checkOutput("rst_saved_ip", 32'(saved_ip), 32'h0);
        checkOutput("rst_wrap_mem_addr", 32'(wbus.mem_addr), 32'h0000ffff);
        @(negedge clk) reset_n = 1'b1;

        // Sequential fetch, zero-wait memory.
        @(negedge clk);
        checkOutput("seq_addr_hi", 32'(bus.mem_addr), 32'h0000);
        @(negedge clk);
        checkOutput("seq_addr_lo", 32'(bus.mem_addr), 32'h0001);
        @(negedge clk);
        checkOutput("seq_valid0", 32'(bus.instr_valid), 32'd1);
        checkOutput("seq_instr0", 32'(bus.instr), 32'h1234);
        checkOutput("seq_addr0", 32'(bus.instr_addr), 32'h0000);

        // Interrupt raised while 0x0002 is being delivered.
        repeat (4) @(posedge clk);
        #1 irq_req = 1'b1;
        @(negedge clk);
        checkOutput("seq_instr1", 32'(bus.instr), 32'h5678);
        checkOutput("seq_addr1", 32'(bus.instr_addr), 32'h0002);
        @(negedge clk);
        checkOutput("irq_ack_pulse", 32'(irq_ack), 32'd1);
        @(negedge clk);
        checkOutput("isr_vector", 32'(bus.mem_addr), 32'hff00);
        checkOutput("isr_in_isr", 32'(in_isr), 32'd1);
        checkOutput("isr_saved_ip", 32'(saved_ip), 32'h0004);
        checkOutput("isr_ack_done", 32'(irq_ack), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("irq_masked", 32'(irq_ack), 32'd0);
        @(negedge clk);
        checkOutput("isr_next", 32'(bus.mem_addr), 32'hff02);
        @(posedge clk); #1;
        iret    = 1'b1;
        irq_req = 1'b0;
        @(posedge clk); #1;
        iret = 1'b0;
        @(negedge clk);
        checkOutput("iret_in_isr", 32'(in_isr), 32'd0);
        checkOutput("iret_addr", 32'(bus.mem_addr), 32'h0004);
        @(negedge clk);
        checkOutput("iret_fetch", 32'(bus.mem_addr), 32'h0004);

        // Jumps relative to the accepted instruction at 0x0010.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.instr_valid && bus.instr_addr == 16'h0010) found = 1'b1;
        end
        checkOutput("reach_0010", 32'(found), 32'd1);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'hfe, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'h7f, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("jump_back", 32'(bus.mem_addr), 32'h0010);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("jump_fwd", 32'(bus.mem_addr), 32'h0091);
        @(posedge clk);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("jump_in_lo_addr", 32'(bus.mem_addr), 32'h0092);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        ack_delay = 2;
        @(negedge clk);
        checkOutput("jump_drop_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("jump_drop_addr", 32'(bus.mem_addr), 32'h0012);

        // Backpressure with slow memory.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.instr_valid) found = 1'b1;
        end
        checkOutput("bp_reach", 32'(found), 32'd1);
        checkOutput("bp_instr", 32'(bus.instr), 32'({mem[16'h0012], mem[16'h0013]}));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(bus.instr_valid), 32'd1);
            checkOutput("bp_hold_addr", 32'(bus.instr_addr), 32'h0012);
        end

        // Randomized traffic.
        @(posedge clk); #1;
        rand_delay = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 40) == 0, 8'($urandom), ($urandom % 60) == 0,
                          (($urandom % 30) == 0) ? ~irq_req : irq_req, ($urandom % 3) != 0);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of an ISR low-byte read.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        rand_delay = 1'b0;
        ack_delay  = 1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (m_in_isr && !m_boundary && m_bytes == 1) found = 1'b1;
        end
        checkOutput("reach_isr_lo", 32'(found), 32'd1);
        checkOutput("pre_reset_rd_en", 32'(bus.mem_rd_en), 32'd1);
        #1;
        reset_n = 1'b0;
        irq_req = 1'b0;
        #1;
        checkOutput("async_rd_en", 32'(bus.mem_rd_en), 32'd0);
        checkOutput("async_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("async_in_isr", 32'(in_isr), 32'd0);
        checkOutput("async_addr", 32'(bus.mem_addr), 32'h0);
        checkOutput("async_instr", 32'(bus.instr), 32'h0);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        checkOutput("restart_rd_en", 32'(bus.mem_rd_en), 32'd1);
        checkOutput("restart_addr", 32'(bus.mem_addr), 32'h0);
        repeat (40) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
